// File: rtl/jk_flip_flop.sv
// Array of WIDTH independent JK flip-flops with a synchronous active-low reset.
// Define JKFF_QBAR_EN to add the registered complement output QN.
module jk_flip_flop #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             CLK,
    input  logic             nRST
`ifdef JKFF_QBAR_EN
   ,output logic [WIDTH-1:0] QN
`endif
);

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (jk_op_e'({J[i], K[i]}))
                JK_CLEAR:  state_d[i] = 1'b0;
                JK_SET:    state_d[i] = 1'b1;
                JK_TOGGLE: state_d[i] = ~state_q[i];
                default:   state_d[i] = state_q[i];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign Q = state_q;

`ifdef JKFF_QBAR_EN
    // Separate flop so QN has no combinational inverter between the register and the pin.
    logic [WIDTH-1:0] qn_d;
    logic [WIDTH-1:0] qn_q;

    always_comb begin
        qn_d = ~state_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            qn_q <= ~RESET_VALUE;
        end else begin
            qn_q <= qn_d;
        end
    end

    assign QN = qn_q;
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop: a 1-bit cell and a 4-bit array checked against
// expected values queued at stimulus time and popped after each rising edge.
module tb_jk_flip_flop;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk;
    logic       nrst;
    logic       j1, k1;
    logic [0:0] q1;
    logic [3:0] j4, k4, q4;
`ifdef JKFF_QBAR_EN
    logic [0:0] qn1;
    logic [3:0] qn4;
`endif

    int total = 0;
    int bad   = 0;

    logic [0:0] sb1[$];
    logic [3:0] sb4[$];

    jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .Q(q1), .J(j1), .K(k1), .CLK(clk), .nRST(nrst)
`ifdef JKFF_QBAR_EN
       ,.QN(qn1)
`endif
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(RV4)) u_dut4 (
        .Q(q4), .J(j4), .K(k4), .CLK(clk), .nRST(nrst)
`ifdef JKFF_QBAR_EN
       ,.QN(qn4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [0:0] e1;
        logic [3:0] e4;
        nrst = 1'b0;
        j1 = 1'b1; k1 = 1'b0;
        j4 = 4'b1111; k4 = 4'b0000;
        sb1.push_back(1'b0);
        sb4.push_back(RV4);
        tick();
        e1 = sb1.pop_front();
        e4 = sb4.pop_front();
        total++;
        if (q1 !== e1) begin
            bad++; $display("FAIL reset_q1: got %b want %b", q1, e1);
        end
        total++;
        if (q4 !== e4) begin
            bad++; $display("FAIL reset_q4: got %b want %b", q4, e4);
        end
`ifdef JKFF_QBAR_EN
        total++;
        if (qn1 !== ~e1) begin
            bad++; $display("FAIL reset_qn1: got %b want %b", qn1, ~e1);
        end
        total++;
        if (qn4 !== ~e4) begin
            bad++; $display("FAIL reset_qn4: got %b want %b", qn4, ~e4);
        end
`endif
    endtask

    task automatic test_set_hold_clear();
        logic [1:0] jk  [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        logic       exp [5] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        logic [0:0] e1;
        nrst = 1'b1;
        j4 = 4'b0000; k4 = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            {j1, k1} = jk[i];
            sb1.push_back(exp[i]);
            tick();
            e1 = sb1.pop_front();
            total++;
            if (q1 !== e1) begin
                bad++; $display("FAIL set_hold_clear[%0d]: got %b want %b", i, q1, e1);
            end
        end
    endtask

    task automatic test_toggle();
        logic [0:0] m;
        logic [0:0] e1;
        m = 1'b0;
        j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m = ~m;
            sb1.push_back(m);
            tick();
            e1 = sb1.pop_front();
            total++;
            if (q1 !== e1) begin
                bad++; $display("FAIL toggle[%0d]: got %b want %b", i, q1, e1);
            end
        end
        j1 = 1'b0; k1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb1.push_back(m);
            tick();
            e1 = sb1.pop_front();
            total++;
            if (q1 !== e1) begin
                bad++; $display("FAIL toggle_hold[%0d]: got %b want %b", i, q1, e1);
            end
        end
    endtask

    task automatic test_reset_mid_toggle();
        logic [0:0] e1;
        // set to 1, reset during a toggle request, then toggle out of reset
        logic [2:0] nrst_seq [3] = '{3'b1_10, 3'b0_11, 3'b1_11};
        logic       exp      [3] = '{1'b1,    1'b0,    1'b1};
        for (int i = 0; i < 3; i++) begin
            {nrst, j1, k1} = nrst_seq[i];
            sb1.push_back(exp[i]);
            tick();
            e1 = sb1.pop_front();
            total++;
            if (q1 !== e1) begin
                bad++; $display("FAIL reset_mid_toggle[%0d]: got %b want %b", i, q1, e1);
            end
        end
    endtask

    task automatic test_async_reset_ignored();
        logic [0:0] e1;
        j1 = 1'b0; k1 = 1'b0;
        nrst = 1'b0;
        #2;
        total++;
        if (q1 !== 1'b1) begin
            bad++; $display("FAIL async_reset_mid_cycle: got %b want %b", q1, 1'b1);
        end
        nrst = 1'b1;
        sb1.push_back(1'b1);
        tick();
        e1 = sb1.pop_front();
        total++;
        if (q1 !== e1) begin
            bad++; $display("FAIL async_reset_next_edge: got %b want %b", q1, e1);
        end
    endtask

    task automatic test_glitch();
        logic [0:0] e1;
        j1 = 1'b0; k1 = 1'b1;
        sb1.push_back(1'b0);
        tick();
        e1 = sb1.pop_front();
        total++;
        if (q1 !== e1) begin
            bad++; $display("FAIL glitch_setup: got %b want %b", q1, e1);
        end
        k1 = 1'b0;
        #2 j1 = 1'b1;
        #2 j1 = 1'b0;
        total++;
        if (q1 !== 1'b0) begin
            bad++; $display("FAIL glitch_mid_cycle: got %b want %b", q1, 1'b0);
        end
        sb1.push_back(1'b0);
        tick();
        e1 = sb1.pop_front();
        total++;
        if (q1 !== e1) begin
            bad++; $display("FAIL glitch_next_edge: got %b want %b", q1, e1);
        end
    endtask

    task automatic test_independence();
        logic [3:0] e4;
        nrst = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;
        sb4.push_back(RV4);
        tick();
        e4 = sb4.pop_front();
        total++;
        if (q4 !== e4) begin
            bad++; $display("FAIL indep_reset: got %b want %b", q4, e4);
        end
        // From 1010: bit3 hold=1, bit2 clear=0, bit1 set=1, bit0 toggle 0->1.
        nrst = 1'b1;
        j4 = 4'b0011; k4 = 4'b0101;
        sb4.push_back(4'b1011);
        tick();
        e4 = sb4.pop_front();
        total++;
        if (q4 !== e4) begin
            bad++; $display("FAIL indep_q: got %b want %b", q4, e4);
        end
`ifdef JKFF_QBAR_EN
        total++;
        if (qn4 !== ~e4) begin
            bad++; $display("FAIL indep_qn: got %b want %b", qn4, ~e4);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] m;
        logic [3:0] e4;
        m = 4'b1011;
        for (int i = 0; i < 40; i++) begin
            j4   = 4'($urandom);
            k4   = 4'($urandom);
            nrst = ($urandom_range(0, 7) != 0);
            // characteristic equation Q+ = J&~Q | ~K&Q
            m = !nrst ? RV4 : ((j4 & ~m) | (~k4 & m));
            sb4.push_back(m);
            tick();
            e4 = sb4.pop_front();
            total++;
            if (q4 !== e4) begin
                bad++; $display("FAIL random[%0d]: got %b want %b", i, q4, e4);
            end
`ifdef JKFF_QBAR_EN
            total++;
            if (qn4 !== ~e4) begin
                bad++; $display("FAIL random_qn[%0d]: got %b want %b", i, qn4, ~e4);
            end
`endif
        end
    endtask

    initial begin
        nrst = 1'b0;
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;
        #1;
        test_reset();
        test_set_hold_clear();
        test_toggle();
        test_reset_mid_toggle();
        test_async_reset_ignored();
        test_glitch();
        test_independence();
        test_random();
        total++;
        if (sb1.size() != 0 || sb4.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d/%0d want 0/0", sb1.size(), sb4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
